aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port n_rst  in  1  asynchronous active-low reset.
REQ-003 SHALL have port start  in  1  request to encrypt data_in; sampled only in IDLE.
REQ-004 SHALL have port data_in  in  128  plaintext block, captured on the accepting edge.
REQ-005 SHALL have port sb_sr_result  in  128  combinational SubBytes+ShiftRows result of stage_data.
REQ-006 SHALL have port mc_result  in  128  combinational mix_col result of stage_data.
REQ-007 SHALL have port ark_result  in  128  combinational AddRoundKey result of stage_data with key for count_out.
REQ-008 SHALL have port stage_data  out  128  current AES state register, fed to all stage units.
REQ-009 SHALL have port count_out  out  4  current round number (0..10), fed to mix_col and key schedule.
REQ-010 SHALL have port busy  out  1  high in every state except IDLE.
REQ-011 SHALL have port done  out  1  single-cycle completion pulse.
REQ-012 SHALL have port data_out  out  128  registered ciphertext, held until next completion.

Function
REQ-013 SHALL implement FSM states IDLE, INIT_ARK, SUBSHIFT, MIXCOL, ADDKEY, DONE; one cycle per state.
REQ-014 IDLE with start=1 SHALL load stage_data<=data_in, count_out<=0, go to INIT_ARK; start=0 stays IDLE.
REQ-015 INIT_ARK SHALL load stage_data<=ark_result, count_out<=1, go to SUBSHIFT.
REQ-016 SUBSHIFT SHALL load stage_data<=sb_sr_result; next MIXCOL if count_out<10, else ADDKEY.
REQ-017 MIXCOL SHALL load stage_data<=mc_result, go to ADDKEY.
REQ-018 ADDKEY SHALL load stage_data<=ark_result; if count_out=10 load data_out<=ark_result and go to DONE, else increment count_out and go to SUBSHIFT.
REQ-019 DONE SHALL assert done for exactly one cycle, go to IDLE, set count_out<=0.
REQ-020 Latency: done SHALL be high in the cycle after the 31st rising edge counted from (and including) the start-accepting edge; busy high 31 cycles.
REQ-021 Round 10 SHALL skip MIXCOL; rounds 1..9 SHALL each take exactly SUBSHIFT, MIXCOL, ADDKEY.
REQ-022 start asserted while busy (including DONE) SHALL be ignored; no queuing.
REQ-023 count_out SHALL never exceed 10; no wrap.
REQ-024 stage_data SHALL hold its value in IDLE and DONE.

Reset
REQ-025 n_rst=0 SHALL immediately force IDLE, stage_data=0, data_out=0, count_out=0, busy=0, done=0.
REQ-026 Reset mid-operation SHALL abandon the block with no done pulse; first start after release SHALL behave as from power-up.

Configuration
REQ-027 Macro AES_ROUND_CTRL_ABORT_EN defined SHALL add input port abort (1 bit); abort=1 in any busy state SHALL go to IDLE on the next edge, count_out<=0, no done, data_out unchanged; abort in DONE SHALL not suppress done; abort in IDLE SHALL be ignored; abort and start together in IDLE SHALL accept start.
REQ-028 Macro undefined SHALL omit the abort port and all abort logic.

Verification
REQ-029 Reset: n_rst low mid-round 5 -> all outputs 0 asynchronously, no done; new start after release -> correct ciphertext.
REQ-030 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data_in 00112233445566778899aabbccddeeff, golden stage units -> data_out 69c4e0d86a7b0430d8cdb78070b4c55a, done at cycle 31.
REQ-031 Sequence check: state trace INIT_ARK, (SUBSHIFT, MIXCOL, ADDKEY)x9, SUBSHIFT, ADDKEY, DONE; count_out 0,1..10,0; mc_result never loaded at count_out=10.
REQ-032 Stage mux: mc_result stub returns 47fe224ad5fd1b67ab8d4fa573fb166b for stage_data a2b87eb552b63484ac44cbefeb507f31 -> that value appears on stage_data the cycle after MIXCOL.
REQ-033 Start while busy: pulse start at cycles 5 and 30 -> single done, data_out unchanged from first block; start held continuously -> back-to-back blocks, one IDLE cycle between.
REQ-034 With AES_ROUND_CTRL_ABORT_EN: abort at round 4 -> IDLE next cycle, no done, data_out keeps previous ciphertext.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// AES-128 encryption round sequencer: steps stage_data through external SubBytes/ShiftRows,
// MixColumns and AddRoundKey units. Define AES_ROUND_CTRL_ABORT_EN to add the abort input.
`timescale 1ns/1ps
module aes_round_ctrl (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic         abort,
`endif
    input  logic [127:0] data_in,
    input  logic [127:0] sb_sr_result,
    input  logic [127:0] mc_result,
    input  logic [127:0] ark_result,
    output logic [127:0] stage_data,
    output logic [3:0]   count_out,
    output logic         busy,
    output logic         done,
    output logic [127:0] data_out
);

    localparam logic [3:0] LAST_ROUND = 4'd10;

    typedef enum logic [2:0] {
        IDLE,
        INIT_ARK,
        SUBSHIFT,
        MIXCOL,
        ADDKEY,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] stage_q, stage_d;
    logic [127:0] dout_q, dout_d;
    logic [3:0]   count_q, count_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            dout_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            dout_q  <= dout_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        dout_d  = dout_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    stage_d = data_in;
                    count_d = '0;
                    state_d = INIT_ARK;
                end
            end
            INIT_ARK: begin
                stage_d = ark_result;
                count_d = 4'd1;
                state_d = SUBSHIFT;
            end
            SUBSHIFT: begin
                stage_d = sb_sr_result;
                // the final round has no MixColumns step
                state_d = (count_q < LAST_ROUND) ? MIXCOL : ADDKEY;
            end
            MIXCOL: begin
                stage_d = mc_result;
                state_d = ADDKEY;
            end
            ADDKEY: begin
                stage_d = ark_result;
                if (count_q >= LAST_ROUND) begin
                    dout_d  = ark_result;
                    state_d = DONE;
                end else begin
                    count_d = count_q + 4'd1;
                    state_d = SUBSHIFT;
                end
            end
            DONE: begin
                count_d = '0;
                state_d = IDLE;
            end
            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase
`ifdef AES_ROUND_CTRL_ABORT_EN
        // DONE is excluded so a finished block always reports completion
        if (abort && state_q != IDLE && state_q != DONE) begin
            state_d = IDLE;
            count_d = '0;
            stage_d = stage_q;
            dout_d  = dout_q;
        end
`endif
    end

    assign stage_data = stage_q;
    assign count_out  = count_q;
    assign data_out   = dout_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural AES stage units, a plain AES-128 reference and directed
// plus randomised blocks covering latency, round sequence, busy-start, reset and optional abort.
`timescale 1ns/1ps
module tb_aes_round_ctrl;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic [127:0] data_in;
    logic [127:0] sb_sr_result, mc_result, ark_result;
    logic [127:0] stage_data, data_out;
    logic [3:0]   count_out;
    logic         busy, done;
`ifdef AES_ROUND_CTRL_ABORT_EN
    logic         abort;
`endif

    int           checks = 0;
    int           errors = 0;
    int           mode   = 0;     // 0 real AES units, 1 MixColumns stub, 2 tagging units
    logic [127:0] rk [0:15];
    logic [127:0] last_ct;

    localparam logic [127:0] STUB_IN  = 128'ha2b87eb552b63484ac44cbefeb507f31;
    localparam logic [127:0] STUB_OUT = 128'h47fe224ad5fd1b67ab8d4fa573fb166b;

    aes_round_ctrl dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .abort        (abort),
`endif
        .data_in      (data_in),
        .sb_sr_result (sb_sr_result),
        .mc_result    (mc_result),
        .ark_result   (ark_result),
        .stage_data   (stage_data),
        .count_out    (count_out),
        .busy         (busy),
        .done         (done),
        .data_out     (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq, inv;
        sq = b;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-8*(4*c)   -: 8];
            a1 = s[127-8*(4*c+1) -: 8];
            a2 = s[127-8*(4*c+2) -: 8];
            a3 = s[127-8*(4*c+3) -: 8];
            o[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int r = 11; r < 16; r++) rk[r] = '0;
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            s = shift_rows(sub_bytes(s));
            if (r < 10) s = mix_columns(s);
            s = s ^ rk[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // tag written into the top byte by each unit in mode 2: ark/sb/mc
    function automatic logic [7:0] unit_tag(input int code);
        case (code)
            0:       return 8'ha7;
            1:       return 8'h5b;
            2:       return 8'h3c;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        sb_sr_result = shift_rows(sub_bytes(stage_data));
        mc_result    = mix_columns(stage_data);
        ark_result   = stage_data ^ rk[count_out];
        if (mode == 1) begin
            sb_sr_result = STUB_IN;
            mc_result    = (stage_data == STUB_IN) ? STUB_OUT : '0;
        end else if (mode == 2) begin
            ark_result   = {unit_tag(0), stage_data[119:0]};
            sb_sr_result = {unit_tag(1), stage_data[119:0]};
            mc_result    = {unit_tag(2), stage_data[119:0]};
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One block from the accepting edge to the first IDLE cycle after DONE.
    task automatic run_block(input logic [127:0] pt, input bit hold, input bit pulse);
        int           st[$];
        int           cn[$];
        int           n;
        logic [127:0] exp_ct;
        st.push_back(0); cn.push_back(0);
        for (int r = 1; r <= 10; r++) begin
            st.push_back(1); cn.push_back(r);
            if (r < 10) begin st.push_back(2); cn.push_back(r); end
            st.push_back(0); cn.push_back(r);
        end
        st.push_back(3); cn.push_back(10);
        n = st.size();
        exp_ct = aes_ref(pt);
        data_in = pt;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int cyc = 1; cyc <= n; cyc++) begin
            chk("busy", 128'(busy), 128'(1'b1));
            chk("done_timing", 128'(done), 128'(cyc == n));
            chk("count_out", 128'(count_out), 128'(cn[cyc-1]));
            if (mode == 2)
                chk("unit_trace", 128'(stage_data[127:120]),
                    128'((cyc == 1) ? pt[127:120] : unit_tag(st[cyc-2])));
            if (mode == 1 && st[cyc-1] == 2) chk("mc_stub_in", stage_data, STUB_IN);
            if (mode == 1 && cyc > 1 && st[cyc-2] == 2) chk("mc_stub_out", stage_data, STUB_OUT);
            if (mode == 0 && cyc == n) chk("data_out_done", data_out, exp_ct);
            if (pulse && (cyc == 5 || cyc == 30 || cyc == 31)) begin
                start = 1'b1;
                data_in = rnd128();
            end else if (!hold) begin
                start = 1'b0;
            end
            tick();
        end
        chk("idle_busy", 128'(busy), 128'(1'b0));
        chk("idle_done", 128'(done), 128'(1'b0));
        chk("idle_count", 128'(count_out), 128'(4'd0));
        if (mode == 0) begin
            chk("data_out", data_out, exp_ct);
            chk("stage_hold", stage_data, exp_ct);
            last_ct = exp_ct;
        end
        if (mode == 2) chk("stage_hold_tag", 128'(stage_data[127:120]), 128'(unit_tag(0)));
        if (!hold) start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pt;
        n_rst = 1'b0;
        start = 1'b0;
        data_in = '0;
        last_ct = '0;
`ifdef AES_ROUND_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        #12;
        chk("rst_stage", stage_data, 128'h0);
        chk("rst_dout", data_out, 128'h0);
        chk("rst_count", 128'(count_out), 128'(4'd0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_done", 128'(done), 128'(1'b0));
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        tick();
        chk("idle_no_start", 128'(busy), 128'(1'b0));

        // FIPS-197 C.1 known answer
        run_block(128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0);
        chk("fips_c1", data_out, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        mode = 2;
        run_block({8'h11, rnd128() >> 8}, 1'b0, 1'b0);
        mode = 1;
        run_block(rnd128(), 1'b0, 1'b0);
        mode = 0;

        // start pulses while busy and during DONE are dropped
        run_block(rnd128(), 1'b0, 1'b1);
        repeat (3) begin
            tick();
            chk("no_second_busy", 128'(busy), 128'(1'b0));
            chk("no_second_done", 128'(done), 128'(1'b0));
            chk("data_out_kept", data_out, last_ct);
        end

        // start held high: back-to-back blocks with a single IDLE cycle between
        run_block(rnd128(), 1'b1, 1'b0);
        run_block(rnd128(), 1'b1, 1'b0);
        start = 1'b0;
        tick();

        for (int k = 0; k < 4; k++) begin
            expand_key(rnd128());
            run_block(rnd128(), 1'b0, 1'b0);
            tick();
        end

        // reset during round 5
        data_in = rnd128();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (13) tick();
        chk("pre_rst_round", 128'(count_out), 128'(4'd5));
        #3 n_rst = 1'b0;
        #1;
        chk("mid_rst_stage", stage_data, 128'h0);
        chk("mid_rst_dout", data_out, 128'h0);
        chk("mid_rst_count", 128'(count_out), 128'(4'd0));
        chk("mid_rst_busy", 128'(busy), 128'(1'b0));
        chk("mid_rst_done", 128'(done), 128'(1'b0));
        tick();
        chk("rst_hold_done", 128'(done), 128'(1'b0));
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        chk("post_rst_done", 128'(done), 128'(1'b0));
        run_block(rnd128(), 1'b0, 1'b0);

`ifdef AES_ROUND_CTRL_ABORT_EN
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", 128'(busy), 128'(1'b0));
        data_in = rnd128();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_with_start", 128'(busy), 128'(1'b1));
        repeat (10) tick();
        chk("abort_round", 128'(count_out), 128'(4'd4));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 128'(busy), 128'(1'b0));
        chk("abort_done", 128'(done), 128'(1'b0));
        chk("abort_count", 128'(count_out), 128'(4'd0));
        chk("abort_dout", data_out, last_ct);
        repeat (3) begin
            tick();
            chk("abort_no_done", 128'(done), 128'(1'b0));
        end
        pt = rnd128();
        data_in = pt;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        chk("abort_in_done", 128'(done), 128'(1'b1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_in_done_idle", 128'(busy), 128'(1'b0));
        chk("abort_in_done_dout", data_out, aes_ref(pt));
`else
        pt = rnd128();
        run_block(pt, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
